// File: rtl/serial_pkg.sv
// Shared types and sizing helpers for the bit_serializer slice.
// BIT_SERIALIZER_PARITY_EN appends one even-parity bit to every frame.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Bits needed to hold counts 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; the head bit is the next bit to send.
module piso_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             head_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  // NOTE: a datapath register normally needs no reset, but this one is cleared
  // so the idle state is fully deterministic for the downstream detector.
  always_ff @(posedge clk_i) begin
    if (clear_i) sr_q <= '0;
    else         sr_q <= sr_d;
  end

  assign head_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding the sequence detector's w input.
// Optional BIT_SERIALIZER_PARITY_EN adds a trailing even-parity bit per frame.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int FRAME_LEN = frame_len(WIDTH);
  localparam int CNT_W     = cnt_width(FRAME_LEN);
  localparam int GAP_W     = cnt_width(GAP);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             last_cnt;
  logic             accept;
  logic             head;

  assign last_cnt = (bit_cnt_q == '0);
  assign accept   = in_valid & in_ready;

  // NOTE: every output gets a default before the case so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready   = 1'b0;
    w_valid    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    if (!Reset) begin
      case (state_q)
        ST_IDLE:  in_ready = 1'b1;
        ST_SHIFT: begin
          w_valid    = 1'b1;
          busy       = 1'b1;
          frame_done = last_cnt;
          in_ready   = last_cnt && (GAP == 0);
        end
        ST_GAP:   busy = 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = CNT_LOAD;
        end
      end
      ST_SHIFT: begin
        if (!last_cnt) begin
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else if (accept) begin
          bit_cnt_d = CNT_LOAD;     // back-to-back frame, no bubble
        end else if (GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d   = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  piso_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_piso (
    .clk_i  (Clock),
    .clear_i(Reset),
    .load_i (accept),
    .shift_i(state_q == ST_SHIFT),
    .data_i (in_data),
    .head_o (head)
  );

`ifdef BIT_SERIALIZER_PARITY_EN
  logic parity_q;

  always_ff @(posedge Clock) begin
    if (Reset)       parity_q <= 1'b0;
    else if (accept) parity_q <= ^in_data;
  end

  // The parity bit occupies the final counter slot, after all data bits.
  assign w = w_valid & (last_cnt ? parity_q : head);
`else
  assign w = w_valid & head;
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: three serializer instances against a queue-level model.
// Honours BIT_SERIALIZER_PARITY_EN when the bundle is built with it.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = 8 + PAR;
  localparam int GAPS [3] = '{0, 2, 0};
  localparam bit MSBF [3] = '{1'b1, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] vld = '0;
  logic [7:0] din [3];
  logic [2:0] rdy, wd, wv, bsy, fd;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_dut0 (
    .Clock(clk), .Reset(rst), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
    .w(wd[0]), .w_valid(wv[0]), .busy(bsy[0]), .frame_done(fd[0]));
  bit_serializer #(.WIDTH(8), .GAP(2), .MSB_FIRST(1'b1)) u_dut1 (
    .Clock(clk), .Reset(rst), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
    .w(wd[1]), .w_valid(wv[1]), .busy(bsy[1]), .frame_done(fd[1]));
  bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u_dut2 (
    .Clock(clk), .Reset(rst), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
    .w(wd[2]), .w_valid(wv[2]), .busy(bsy[2]), .frame_done(fd[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per instance, the bits still owed on w (bit 0 goes next) and the
  // number of idle-gap cycles still owed after the frame.
  logic [31:0] mvec [3] = '{default: '0};
  int          mleft[3] = '{default: 0};
  int          mgap [3] = '{default: 0};

  function automatic logic [31:0] frame_vec(input int d, input logic [7:0] data);
    logic [31:0] v = '0;
    for (int k = 0; k < 8; k++) v[k] = MSBF[d] ? data[7-k] : data[k];
    if (PAR != 0) v[8] = ^data;
    return v;
  endfunction

  function automatic logic exp_rdy(input int d);
    if (rst) return 1'b0;
    return (mleft[d] == 0 && mgap[d] == 0) || (mleft[d] == 1 && GAPS[d] == 0);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        mleft[d] = 0;
        mgap[d]  = 0;
        mvec[d]  = '0;
      end else begin
        logic acc;
        acc = vld[d] && exp_rdy(d);
        if (mleft[d] > 0) begin
          mvec[d]  = mvec[d] >> 1;
          mleft[d] = mleft[d] - 1;
          if (mleft[d] == 0) mgap[d] = GAPS[d];
        end else if (mgap[d] > 0) begin
          mgap[d] = mgap[d] - 1;
        end
        if (acc) begin
          mvec[d]  = frame_vec(d, din[d]);
          mleft[d] = FLEN;
          mgap[d]  = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        logic ev;
        ev = !rst && mleft[d] > 0;
        check($sformatf("dut%0d w_valid", d),    32'(wv[d]),  32'(ev));
        check($sformatf("dut%0d w", d),          32'(wd[d]),  32'(ev & mvec[d][0]));
        check($sformatf("dut%0d busy", d),       32'(bsy[d]), 32'(!rst && (mleft[d] > 0 || mgap[d] > 0)));
        check($sformatf("dut%0d frame_done", d), 32'(fd[d]),  32'(!rst && mleft[d] == 1));
        check($sformatf("dut%0d in_ready", d),   32'(rdy[d]), 32'(exp_rdy(d)));
      end
    end
  end

  // Offer a word and return just after the edge that accepted it.
  task automatic send(input int d, input logic [7:0] data);
    int n;
    din[d] = data;
    vld[d] = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy[d]) break;
    end
    check($sformatf("dut%0d accept timeout", d), 32'(n < 100), 32'd1);
    @(posedge clk);
    #1 vld[d] = 1'b0;
  endtask

  // Observe n cycles; valid bits are shifted in first-bit-most-significant.
  task automatic collect(input int d, input int n, output logic [31:0] bits,
                         output int nv, output int nfd, output int nrdy,
                         output int nbusy, output int fd_at);
    bits = '0; nv = 0; nfd = 0; nrdy = 0; nbusy = 0; fd_at = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (wv[d]) bits = {bits[30:0], wd[d]};
      nv    += int'(wv[d]);
      nrdy  += int'(rdy[d]);
      nbusy += int'(bsy[d]);
      if (fd[d]) begin
        nfd++;
        fd_at = i + 1;
      end
      if (vld[d] && rdy[d]) begin
        @(posedge clk);
        #1 vld[d] = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] expv(input logic [7:0] data);
    return (PAR != 0) ? {23'd0, data, ^data} : {24'd0, data};
  endfunction

  initial begin
    logic [31:0] bits;
    int nv, nfd, nrdy, nbusy, fd_at;
    for (int d = 0; d < 3; d++) din[d] = '0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset rdy", 32'(rdy), 32'b111);
    check("reset wv",  32'(wv | bsy | fd | wd), 32'd0);

    // Basic frame B3, MSB first.
    send(0, 8'hB3);
    collect(0, FLEN + 1, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("basic bits",  bits, (PAR != 0) ? 32'h167 : 32'hB3);
    check("basic nv",    32'(nv), 32'(FLEN));
    check("basic fd_at", 32'(fd_at), 32'(FLEN));
    check("basic nfd",   32'(nfd), 32'd1);
    check("basic rdy",   32'(nrdy), 32'd2);

    // Back-to-back FF then 00, second accepted in the frame_done cycle.
    send(0, 8'hFF);
    din[0] = 8'h00;
    vld[0] = 1'b1;
    collect(0, 2 * FLEN, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("b2b bits",  bits, (expv(8'hFF) << FLEN) | expv(8'h00));
    check("b2b nv",    32'(nv), 32'(2 * FLEN));
    check("b2b nfd",   32'(nfd), 32'd2);
    check("b2b fd_at", 32'(fd_at), 32'(2 * FLEN));

    // Stall: 5A offered from mid-frame waits for the final-bit cycle.
    send(0, 8'h3C);
    collect(0, 3, bits, nv, nfd, nrdy, nbusy, fd_at);
    din[0] = 8'h5A;
    vld[0] = 1'b1;
    collect(0, FLEN - 3, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("stall rdy",  32'(nrdy), 32'd1);
    check("stall vld",  32'(vld[0]), 32'd0);
    collect(0, FLEN, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("stall bits", bits, (PAR != 0) ? 32'h0B4 : 32'h5A);
    collect(0, 4, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("stall once", 32'(nv), 32'd0);

    // Gap of 2 between AA and 55.
    send(1, 8'hAA);
    din[1] = 8'h55;
    vld[1] = 1'b1;
    collect(1, FLEN, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("gap bits1", bits, expv(8'hAA));
    check("gap rdy1",  32'(nrdy), 32'd0);
    collect(1, 3, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("gap nv",    32'(nv), 32'd0);
    check("gap rdy",   32'(nrdy), 32'd1);
    check("gap busy",  32'(nbusy), 32'd2);
    check("gap acc",   32'(vld[1]), 32'd0);
    collect(1, FLEN, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("gap bits2", bits, expv(8'h55));
    check("gap nv2",   32'(nv), 32'(FLEN));

    // Reset during bit 4 of F0, with in_valid high during the reset cycle.
    send(0, 8'hF0);
    collect(0, 3, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("abort head", bits, 32'h7);
    @(posedge clk);
    #1 rst = 1'b1;
    din[0] = 8'h81;
    vld[0] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    vld[0] = 1'b0;
    @(negedge clk);
    check("abort outs", {wd[0], wv[0], bsy[0], fd[0]}, 32'd0);
    check("abort rdy",  32'(rdy[0]), 32'd1);
    collect(0, FLEN, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("abort nv",  32'(nv), 32'd0);
    check("abort nfd", 32'(nfd), 32'd0);

    // LSB-first 07 (with parity bit when enabled).
    send(2, 8'h07);
    collect(2, FLEN, bits, nv, nfd, nrdy, nbusy, fd_at);
    check("lsb bits",  bits, (PAR != 0) ? 32'h1C1 : 32'hE0);
    check("lsb fd_at", 32'(fd_at), 32'(FLEN));
    check("lsb nfd",   32'(nfd), 32'd1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
